// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter
// Packet-granular round-robin arbiter that shares the single USB CDC-ACM
// transmit pipe between several byte-stream sources. A granted source keeps
// the pipe until it delivers a stop-marked beat, so packets never interleave.
// A stall timeout reclaims the pipe from a source that goes quiet mid-packet.
//
// Ports:
//   clk_48mhz     - USB clock, all logic on the rising edge
//   reset_n       - asynchronous active-low reset
//   req_data      - per-source bytes, source i in [8i+7:8i]
//   req_start     - per-source first-beat flag (forwarded, not checked)
//   req_stop      - per-source last-beat flag
//   req_valid     - per-source beat valid
//   req_ready     - per-source beat accepted (only the granted bit can be high)
//   out_data      - registered byte to usb_uart pipe_in
//   out_start     - registered start flag
//   out_stop      - registered stop flag
//   out_valid     - registered beat valid
//   out_ready     - downstream accept
//   grant         - one-hot current owner, zero when idle
//   busy          - pipe locked to a source
//   timeout_pulse - one-cycle strobe on a forced release
module usb_tx_arbiter #(
  parameter int N_SOURCES = 4,
  parameter int TIMEOUT   = 4800
) (
  input  logic                   clk_48mhz,
  input  logic                   reset_n,
  input  logic [N_SOURCES*8-1:0] req_data,
  input  logic [N_SOURCES-1:0]   req_start,
  input  logic [N_SOURCES-1:0]   req_stop,
  input  logic [N_SOURCES-1:0]   req_valid,
  output logic [N_SOURCES-1:0]   req_ready,
  output logic [7:0]             out_data,
  output logic                   out_start,
  output logic                   out_stop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_SOURCES-1:0]   grant,
  output logic                   busy,
  output logic                   timeout_pulse
);

  localparam int PW = $clog2(N_SOURCES);
  // A zero TIMEOUT disables the counter; keep it one bit wide so it still exists.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t               state, state_next;
  logic [PW-1:0]        gidx, gidx_next;
  logic [PW-1:0]        last, last_next;
  logic [N_SOURCES-1:0] grant_next;
  logic [CW-1:0]        cnt, cnt_next;

  logic                 found;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        cand;

  logic                 sel_valid;
  logic                 sel_start;
  logic                 sel_stop;
  logic [7:0]           sel_data;
  logic                 room;
  logic                 accept;
  logic                 stall_hit;

  // Beat offered by the current owner.
  assign sel_valid = req_valid[gidx];
  assign sel_start = req_start[gidx];
  assign sel_stop  = req_stop[gidx];
  assign sel_data  = req_data[gidx*8 +: 8];

  // The output register can take a beat when it is empty or being drained.
  assign room      = ~out_valid | out_ready;
  assign req_ready = (state == LOCKED) ? (grant & {N_SOURCES{room}}) : '0;
  assign accept    = (state == LOCKED) & sel_valid & room;
  assign busy      = (state == LOCKED);

  // The owner has been quiet for TIMEOUT consecutive cycles including this one.
  assign stall_hit = (TIMEOUT != 0) && (state == LOCKED) && !sel_valid &&
                     ((int'(cnt) + 1) == TIMEOUT);

  // Round-robin search starting just after the previous owner, so the source
  // that finished last has the lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= N_SOURCES; i++) begin
      cand = PW'((int'(last) + i) % N_SOURCES);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next    = state;
    gidx_next     = gidx;
    last_next     = last;
    grant_next    = grant;
    cnt_next      = cnt;
    timeout_pulse = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (found) begin
          state_next       = LOCKED;
          gidx_next        = pick;
          grant_next       = '0;
          grant_next[pick] = 1'b1;
        end
      end
      LOCKED: begin
        if (sel_valid) begin
          cnt_next = '0;
        end else if ((TIMEOUT != 0) && (int'(cnt) < TIMEOUT)) begin
          cnt_next = cnt + CW'(1);
        end
        // Release on the stop beat itself; a stall releases without a stop beat
        // and lets any beat already in the output register drain on its own.
        if (accept && sel_stop) begin
          state_next = IDLE;
          last_next  = gidx;
          grant_next = '0;
          cnt_next   = '0;
        end else if (stall_hit) begin
          timeout_pulse = 1'b1;
          state_next    = IDLE;
          last_next     = gidx;
          grant_next    = '0;
          cnt_next      = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      gidx  <= '0;
      last  <= PW'(N_SOURCES - 1);
      grant <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      gidx  <= gidx_next;
      last  <= last_next;
      grant <= grant_next;
      cnt   <= cnt_next;
    end
  end

  // Output beat register
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_start <= 1'b0;
      out_stop  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_start <= sel_start;
      out_stop  <= sel_stop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/usb_tx_arbiter.md
# usb_tx_arbiter

Packet-granular round-robin arbiter that shares the single USB CDC-ACM transmit pipe (the `pipe_in` side of `usb_uart`, 8-bit data with start/stop framing) between several on-badge byte-stream sources. Once a source is granted, it holds the pipe until it delivers a stop-marked beat, so messages are never interleaved. A stall timeout reclaims the pipe from a source that goes quiet mid-packet. The block sits between the application sources and `usb_uart`, running in the 48 MHz USB clock domain.

## Interface

Parameters:
- `N_SOURCES`, default 4: number of requesters, legal range 2..8.
- `TIMEOUT`, default 4800: idle cycles mid-packet before forced release; 0 disables the timeout.

Ports:
- `clk_48mhz`, in, 1: the single clock; all logic is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_data`, in, N_SOURCES*8: source i's byte is in bits [8i+7:8i].
- `req_start`, in, N_SOURCES: per-source first-beat-of-packet flag.
- `req_stop`, in, N_SOURCES: per-source last-beat-of-packet flag.
- `req_valid`, in, N_SOURCES: per-source beat valid.
- `req_ready`, out, N_SOURCES: per-source beat accepted; only the granted bit can be high.
- `out_data`, out, 8: registered byte to the `usb_uart` `pipe_in`.
- `out_start`, out, 1: registered start flag.
- `out_stop`, out, 1: registered stop flag.
- `out_valid`, out, 1: registered beat valid.
- `out_ready`, in, 1: downstream accept.
- `grant`, out, N_SOURCES: one-hot index of the current owner; zero when idle.
- `busy`, out, 1: high while the pipe is locked to a source.
- `timeout_pulse`, out, 1: one-cycle strobe on a forced release.

## Operation

- Handshake is valid/ready on both sides. A beat transfers on a clock edge where valid and ready are both high. Once a source asserts valid, it holds valid and its data stable until the beat is accepted.
- **IDLE state:**
  - Search `req_valid` round-robin, starting at `(last+1) mod N_SOURCES`, where `last` is the most recent owner.
  - On the first hit, register the one-hot `grant`, set `busy`, and move to LOCKED.
  - A request is granted whatever its start flag; the start flag is forwarded unchanged and not checked.
- **LOCKED state:**
  - `req_ready[g] = ~out_valid | out_ready` (combinational). All other `req_ready` bits are 0.
  - An accepted beat loads `out_data/out_start/out_stop` and sets `out_valid`.
  - `out_valid` clears when the output beat is taken and no new beat is loaded in the same cycle.
  - When the accepted beat has stop=1:
    - return to IDLE on that same edge;
    - set `last = g`;
    - clear `grant` and `busy`.
- **Timeout:**
  - In LOCKED, a counter counts consecutive cycles with `req_valid[g]` low. It resets to 0 whenever `req_valid[g]` is high and on entry to LOCKED.
  - When the count reaches TIMEOUT (and TIMEOUT is not 0):
    - pulse `timeout_pulse`;
    - return to IDLE and set `last = g`;
    - emit no synthetic stop beat.
  - A beat already in the output register still drains normally.
- Counter width is `$clog2(TIMEOUT+1)` and it saturates, never wrapping. The round-robin pointer is `$clog2(N_SOURCES)` bits and wraps from N_SOURCES-1 to 0.
- Reset (asynchronous) forces:
  - `out_valid`, `out_data`, `out_start`, `out_stop` = 0;
  - `grant` = 0, `busy` = 0, `timeout_pulse` = 0, `req_ready` = 0;
  - state = IDLE, `last = N_SOURCES-1` (so source 0 wins the first arbitration), timeout counter = 0.
- Reset mid-packet abandons the packet. Nothing is replayed after reset.

## Timing

- Grant latency: a request seen in IDLE at edge k produces `grant` and `req_ready` after edge k. The first beat transfers at edge k+1 at the earliest.
- Output latency: an accepted beat appears on `out_*` one cycle after acceptance.
- Throughput: one beat per cycle while `out_ready` is held high.
- Packet gap: one IDLE cycle between a stop beat and the next grant, so at least one empty `out_valid` cycle occurs per packet boundary under continuous traffic.
- Backpressure: `out_ready` low with `out_valid` high drives `req_ready[g]` low in the same cycle. No beat is lost or duplicated.
- Simultaneous stop and new request: the new request is not evaluated until the IDLE cycle. The requester that just finished has lowest priority in that evaluation.
- Single-beat packet (start=1 and stop=1 together): LOCKED lasts exactly one transfer.
- Timeout with TIMEOUT=T: `req_valid[g]` low for T consecutive cycles causes `timeout_pulse` on the T-th cycle and IDLE on the following cycle.

## Test plan

- **Reset, then first arbitration:** after reset, sources 0 and 2 both request → `grant`=0001. Source 0's 3-byte packet 0x41,0x42,0x43 (stop on 0x43) appears on `out_data` in order. `grant`=0100 on the cycle after the gap.
- **Round-robin fairness:** all 4 sources send continuous 2-beat packets → grant order 0,1,2,3,0. No byte interleaving. Exactly one idle `out_valid` cycle between packets.
- **Backpressure:** toggle `out_ready` 1010… during a 5-byte packet → all 5 bytes delivered exactly once, in order. `req_ready[g]` is low exactly when `out_valid`=1 and `out_ready`=0.
- **Timeout:** with TIMEOUT=8, source 1 sends start byte 0x10 then drops valid → `timeout_pulse` for one cycle after 8 idle cycles. Source 2's pending request is granted next.
- **Async reset mid-packet:** assert `reset_n`=0 between edges during source 3's packet → all outputs go to 0 immediately. After release, a source 0 request is granted first.
- **Single-beat packets:** sources 0 and 1 each send start+stop byte 0xAA and 0xBB back-to-back → `out` shows 0xAA, one gap cycle, then 0xBB, both with start=stop=1.
